// File: rtl/bus_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer_if -- bridge-side register port of the countdown timer
// Revision : 1.0
// ============================================================================
interface bus_timer_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface
`default_nettype wire

// File: rtl/bus_timer.sv
`default_nettype none
// ============================================================================
// Module   : bus_timer -- memory-mapped countdown timer (CTRL/PRESET/COUNT),
//            level IRQ; optional prescaler enabled by macro TIMER_PRESCALE_EN
// Revision : 1.0
// ============================================================================
module bus_timer #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    bus_timer_if.slave  bus
);

    localparam logic [1:0] c_ADDR_CTRL   = 2'b00;
    localparam logic [1:0] c_ADDR_PRESET = 2'b01;
    localparam logic [1:0] c_ADDR_COUNT  = 2'b10;
    localparam logic [1:0] c_MODE_RELOAD = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_CNT  = 2'b10,
        S_INT  = 2'b11
    } state_t;

    state_t      r_state,    w_state_nxt;
    logic        r_en,       w_en_nxt;
    logic [1:0]  r_mode,     w_mode_nxt;
    logic        r_im,       w_im_nxt;
    logic [31:0] r_preset,   w_preset_nxt;
    logic [31:0] r_count,    w_count_nxt;
    logic        r_irq_flag, w_irq_flag_nxt;

    logic        w_tick;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_unused_bits;

    assign w_wr_ctrl     = bus.WE && (bus.Addr[3:2] == c_ADDR_CTRL);
    assign w_wr_preset   = bus.WE && (bus.Addr[3:2] == c_ADDR_PRESET);
    assign w_unused_bits = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din[31:4]};

`ifdef TIMER_PRESCALE_EN
    localparam logic [7:0] c_DIV_LAST = 8'(DIV - 1);

    logic [7:0] r_presc;

    assign w_tick = (r_presc == c_DIV_LAST);

    // Runs only while actively counting; any other state parks it at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc <= 8'd0;
        end else if ((r_state == S_CNT) && r_en) begin
            r_presc <= w_tick ? 8'd0 : (r_presc + 8'd1);
        end else begin
            r_presc <= 8'd0;
        end
    end
`else
    logic w_unused_div;

    assign w_tick       = 1'b1;
    assign w_unused_div = (DIV != 0);
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_en_nxt       = r_en;
        w_mode_nxt     = r_mode;
        w_im_nxt       = r_im;
        w_preset_nxt   = r_preset;
        w_count_nxt    = r_count;
        w_irq_flag_nxt = r_irq_flag;

        case (r_state)
            S_IDLE: begin
                if (r_en) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                if (r_mode == c_MODE_RELOAD) begin
                    w_irq_flag_nxt = 1'b0;
                end
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_en) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tick) begin
                    if (r_count <= 32'd1) begin
                        w_count_nxt = 32'd0;
                        w_state_nxt = S_INT;
                    end else begin
                        w_count_nxt = r_count - 32'd1;
                    end
                end
            end
            S_INT: begin
                w_irq_flag_nxt = 1'b1;
                if (r_mode == c_MODE_RELOAD) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_en_nxt    = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // CPU writes override whatever the state machine did to CTRL/irq_flag.
        if (w_wr_ctrl) begin
            w_en_nxt       = bus.Din[0];
            w_mode_nxt     = bus.Din[2:1];
            w_im_nxt       = bus.Din[3];
            w_irq_flag_nxt = 1'b0;
        end
        if (w_wr_preset) begin
            w_preset_nxt = bus.Din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_en       <= 1'b0;
            r_mode     <= 2'b00;
            r_im       <= 1'b0;
            r_preset   <= 32'd0;
            r_count    <= 32'd0;
            r_irq_flag <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_mode     <= w_mode_nxt;
            r_im       <= w_im_nxt;
            r_preset   <= w_preset_nxt;
            r_count    <= w_count_nxt;
            r_irq_flag <= w_irq_flag_nxt;
        end
    end

    always_comb begin
        bus.Dout = 32'd0;
        case (bus.Addr[3:2])
            c_ADDR_CTRL:   bus.Dout = {28'd0, r_im, r_mode, r_en};
            c_ADDR_PRESET: bus.Dout = r_preset;
            c_ADDR_COUNT:  bus.Dout = r_count;
            default:       bus.Dout = 32'd0;
        endcase
    end

    assign bus.IRQ = r_im & r_irq_flag;

endmodule
`default_nettype wire
